// File: rtl/stopwatch_lap_ctrl.sv
// stopwatch_lap_ctrl: hh:mm:ss:cc BCD stopwatch with start/stop/split control and a lap memory
module stopwatch_lap_ctrl #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int TICK_FREQ = 100,
  parameter int LAP_DEPTH = 8,
  localparam int AW = $clog2(LAP_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          split,
  input  logic [AW-1:0] lap_rd_idx,
  output logic [31:0]   disp_bcd,
  output logic [31:0]   lap_rd_bcd,
  output logic [AW:0]   lap_count,
  output logic          lap_full,
  output logic [1:0]    state,
  output logic          ovf
);
  localparam int DIV = CLK_FREQ / TICK_FREQ;
  localparam int DW = $clog2(DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);
  localparam logic [AW:0] DEPTH = (AW + 1)'(LAP_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'b00, RUNNING = 2'b01, SPLIT = 2'b10, STOPPED = 2'b11} state_t;

  state_t state_q, state_d;
  logic start_q, stop_q, split_q;
  logic [DW-1:0] div_q, div_d;
  logic [31:0] cnt_q, cnt_d, cnt_inc, snap_q, snap_d, lap_rd_q, lap_rd_d;
  logic ovf_q, ovf_d, wrap;
  logic [AW:0] lap_count_q, lap_count_d;
  logic [31:0] lap_q [LAP_DEPTH];
  logic [31:0] lap_d [LAP_DEPTH];
  logic ev_start, ev_stop, ev_split, run, tick, clr, snap_ev, wr;

  // Ripple increment over the eight digits; tens of seconds/minutes roll at 5, the rest at 9.
  function automatic logic [32:0] bcd_inc(input logic [31:0] v);
    logic [31:0] r;
    logic c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (c) begin
        if (r[4*i +: 4] == ((i == 3 || i == 5) ? 4'd5 : 4'd9)) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  always_comb begin
    ev_stop = stop & ~stop_q;
    ev_split = split & ~split_q & ~ev_stop;
    ev_start = start & ~start_q & ~ev_stop & ~ev_split;
    run = state_q == RUNNING || state_q == SPLIT;
    tick = run && div_q == DIV_MAX;
    clr = state_q == STOPPED && ev_split;
    snap_ev = run && ev_split;
    wr = snap_ev && lap_count_q != DEPTH;
    {wrap, cnt_inc} = bcd_inc(cnt_q);
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = ev_start ? RUNNING : IDLE;
      RUNNING: state_d = ev_stop ? STOPPED : ev_split ? SPLIT : RUNNING;
      SPLIT:   state_d = ev_stop ? STOPPED : ev_start ? RUNNING : SPLIT;
      STOPPED: state_d = ev_start ? RUNNING : ev_split ? IDLE : STOPPED;
    endcase
    div_d = (clr || tick) ? '0 : run ? div_q + 1'b1 : div_q;
    cnt_d = clr ? '0 : tick ? cnt_inc : cnt_q;
    ovf_d = clr ? 1'b0 : ovf_q | (tick & wrap);
    snap_d = snap_ev ? cnt_q : snap_q;
    lap_count_d = clr ? '0 : wr ? lap_count_q + 1'b1 : lap_count_q;
    lap_d = lap_q;
    if (wr) lap_d[lap_count_q[AW-1:0]] = cnt_q;
    lap_rd_d = ({1'b0, lap_rd_idx} < lap_count_q) ? lap_q[lap_rd_idx] : '0;
  end

  // History flops start high so a button held through reset release is not an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      start_q <= 1'b1;
      stop_q <= 1'b1;
      split_q <= 1'b1;
      div_q <= '0;
      cnt_q <= '0;
      snap_q <= '0;
      ovf_q <= 1'b0;
      lap_count_q <= '0;
      lap_rd_q <= '0;
      lap_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      start_q <= start;
      stop_q <= stop;
      split_q <= split;
      div_q <= div_d;
      cnt_q <= cnt_d;
      snap_q <= snap_d;
      ovf_q <= ovf_d;
      lap_count_q <= lap_count_d;
      lap_rd_q <= lap_rd_d;
      lap_q <= lap_d;
    end
  end

  assign disp_bcd = state_q == SPLIT ? snap_q : cnt_q;
  assign lap_rd_bcd = lap_rd_q;
  assign lap_count = lap_count_q;
  assign lap_full = lap_count_q == DEPTH;
  assign state = state_q;
  assign ovf = ovf_q;
endmodule
